finv_table_loader: RTL and testbench

//  Writer side of the finv reciprocal seed table: computes all (a,b) coefficient pairs at run

---
 rtl/finv_pkg.sv | 32 +++
 rtl/seq_udiv.sv | 65 ++++++
 rtl/finv_table_loader.sv | 124 ++++++++++++
 tb/tb_finv_table_loader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/finv_pkg.sv
// Shared table format for the finv reciprocal seed table: geometry, coefficient widths and
// the loader FSM encoding, so the loader and the table RAM agree on layout.
package finv_pkg;

  localparam int unsigned FINV_ENTRIES   = 1024;
  localparam int unsigned FINV_ADDR_W    = 10;
  localparam int unsigned FINV_COEF_W    = 24;
  localparam int unsigned FINV_DIV_CYC   = 35;
  localparam int unsigned FINV_BASE      = 1024;
  localparam int unsigned FINV_DIVISOR_W = 12;
  localparam int unsigned FINV_QUOT_W    = 25;
  localparam int unsigned FINV_CNT_W     = 6;
  localparam int unsigned FINV_SUM_W     = FINV_QUOT_W + 1;
  localparam int unsigned FINV_SQ_W      = 2 * FINV_COEF_W;

  localparam logic [FINV_DIV_CYC-1:0] FINV_DIVIDEND = 35'h4_0000_0000;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_PRIME,
    LD_DIV,
    LD_SQR,
    LD_WRITE,
    LD_DONE
  } finv_ld_state_t;

  typedef struct packed {
    logic [FINV_COEF_W-1:0] a;
    logic [FINV_COEF_W-1:0] b;
  } finv_coef_t;

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider of the constant FINV_DIVIDEND by a run-time divisor, one
// quotient bit per cycle; the final quotient is also offered combinationally on its last step.
module seq_udiv
  import finv_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [FINV_DIVISOR_W-1:0] divisor,
  output logic                      valid_c,
  output logic [FINV_QUOT_W-1:0]    quotient_c,
  output logic [FINV_QUOT_W-1:0]    quotient
);

  localparam logic [FINV_CNT_W-1:0] LAST = FINV_CNT_W'(FINV_DIV_CYC - 1);

  logic [FINV_DIVISOR_W-1:0] dvsr;
  logic [FINV_DIVISOR_W-1:0] rem;
  logic [FINV_DIVISOR_W-1:0] rem_nx;
  logic [FINV_DIVISOR_W:0]   rem_sh;
  logic [FINV_QUOT_W-1:0]    q_sr;
  logic [FINV_CNT_W-1:0]     cnt;
  logic                      run;
  logic                      ge;

  // One shift-subtract step; dividend bits are consumed MSB first.
  always_comb begin
    rem_sh     = {rem, FINV_DIVIDEND[LAST - cnt]};
    ge         = rem_sh >= {1'b0, dvsr};
    rem_nx     = ge ? FINV_DIVISOR_W'(rem_sh - {1'b0, dvsr}) : FINV_DIVISOR_W'(rem_sh);
    quotient_c = {q_sr[FINV_QUOT_W-2:0], ge};
    valid_c    = run && (cnt == LAST);
  end

  // A new start on the completing edge takes over the working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvsr     <= '0;
      rem      <= '0;
      q_sr     <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      quotient <= '0;
    end else begin
      if (run) begin
        rem  <= rem_nx;
        q_sr <= quotient_c;
        if (valid_c) begin
          run      <= 1'b0;
          quotient <= quotient_c;
        end else begin
          cnt <= cnt + FINV_CNT_W'(1);
        end
      end
      if (start) begin
        dvsr <= divisor;
        rem  <= '0;
        q_sr <= '0;
        cnt  <= '0;
        run  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/finv_table_loader.sv
// Rebuilds the finv reciprocal seed table at run time: one division per entry, then one
// squaring cycle and one RAM write cycle, strictly in address order.
module finv_table_loader
  import finv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   load,
  output logic [FINV_ADDR_W-1:0] addr,
  output logic [FINV_COEF_W-1:0] in_a,
  output logic [FINV_COEF_W-1:0] in_b
);

  localparam logic [FINV_DIVISOR_W-1:0] BASE_D   = FINV_DIVISOR_W'(FINV_BASE);
  localparam logic [FINV_ADDR_W-1:0]    LAST_IDX = FINV_ADDR_W'(FINV_ENTRIES - 1);

  finv_ld_state_t            state;
  finv_ld_state_t            state_nx;
  logic [FINV_ADDR_W-1:0]    idx;
  logic [FINV_QUOT_W-1:0]    q_prev;
  finv_coef_t                coef;
  logic                      div_start_c;
  logic [FINV_DIVISOR_W-1:0] divisor_c;
  logic                      div_valid_c;
  logic [FINV_QUOT_W-1:0]    div_quot_c;
  logic [FINV_QUOT_W-1:0]    div_quot;
  logic [FINV_SUM_W-1:0]     sum_c;
  logic [FINV_COEF_W-1:0]    x0_c;
  logic [FINV_SQ_W-1:0]      sq_c;

  seq_udiv u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (div_start_c),
    .divisor    (divisor_c),
    .valid_c    (div_valid_c),
    .quotient_c (div_quot_c),
    .quotient   (div_quot)
  );

  // Midpoint of adjacent quotients and its square.
  always_comb begin
    sum_c = {1'b0, q_prev} + {1'b0, div_quot};
    x0_c  = FINV_COEF_W'(sum_c >> 1);
    sq_c  = FINV_SQ_W'(x0_c) * FINV_SQ_W'(x0_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LD_IDLE;
    else        state <= state_nx;
  end

  // Next state and divider launch; the divisor always targets q(1025+idx) of the coming DIV.
  always_comb begin
    state_nx    = state;
    div_start_c = 1'b0;
    divisor_c   = BASE_D + FINV_DIVISOR_W'(idx) + FINV_DIVISOR_W'(1);
    case (state)
      LD_IDLE: begin
        if (start) begin
          state_nx    = LD_PRIME;
          div_start_c = 1'b1;
          divisor_c   = BASE_D;
        end
      end
      LD_PRIME: begin
        if (div_valid_c) begin
          state_nx    = LD_DIV;
          div_start_c = 1'b1;
        end
      end
      LD_DIV: begin
        if (div_valid_c) state_nx = LD_SQR;
      end
      LD_SQR: state_nx = LD_WRITE;
      LD_WRITE: begin
        if (idx == LAST_IDX) begin
          state_nx = LD_DONE;
        end else begin
          state_nx    = LD_DIV;
          div_start_c = 1'b1;
          divisor_c   = BASE_D + FINV_DIVISOR_W'(idx) + FINV_DIVISOR_W'(2);
        end
      end
      LD_DONE: state_nx = LD_IDLE;
      default: state_nx = LD_IDLE;
    endcase
  end

  // Datapath and outputs; outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      q_prev <= '0;
      coef   <= '0;
      addr   <= '0;
      load   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (state == LD_IDLE && start) idx <= '0;
      if (state == LD_PRIME && div_valid_c) q_prev <= div_quot_c;
      if (state == LD_SQR) begin
        coef.b <= x0_c;
        coef.a <= FINV_COEF_W'(sq_c >> FINV_COEF_W);
        addr   <= idx;
      end
      if (state == LD_WRITE) begin
        q_prev <= div_quot;
        if (idx != LAST_IDX) idx <= idx + FINV_ADDR_W'(1);
      end
      load <= (state_nx == LD_WRITE);
      busy <= (state_nx != LD_IDLE) && (state_nx != LD_DONE);
      done <= (state_nx == LD_DONE);
    end
  end

  assign in_a = coef.a;
  assign in_b = coef.b;

endmodule

// File: tb/tb_finv_table_loader.sv
// Directed bench for finv_table_loader: reset values, full rebuild against a golden model,
// stray start pulses, async reset mid-run and restart from entry 0.
module tb_finv_table_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        load;
  logic [9:0]  addr;
  logic [23:0] in_a;
  logic [23:0] in_b;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned wr;
  logic        prev_load;
  logic        got_done;
  logic [47:0] g;

  finv_table_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .load  (load),
    .addr  (addr),
    .in_a  (in_a),
    .in_b  (in_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {a, b} for entry i straight from the table formulas.
  function automatic logic [47:0] gold(input int unsigned i);
    longint unsigned k, q0, q1, x0, sq;
    k  = 64'(1024 + i);
    q0 = 64'd17179869184 / k;
    q1 = 64'd17179869184 / (k + 1);
    x0 = (q0 + q1) >> 1;
    sq = x0 * x0;
    return {sq[47:24], x0[23:0]};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    #23;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_in_a", 64'(in_a), 64'd0);
    chk("rst_in_b", 64'(in_b), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Run 1: full rebuild with stray starts while busy and a start on the done cycle.
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    wr        = 0;
    prev_load = 1'b0;
    got_done  = 1'b0;
    for (int c = 1; c <= 40000; c++) begin
      start = (c == 200 || c == 9000 || c == 30001) ? 1'b1 : 1'b0;
      if (c == 1) chk("busy_after_start", 64'(busy), 64'd1);
      if (load) begin
        g = gold(wr);
        if (wr == 0) begin
          chk("first_write_cycle", 64'(c), 64'd72);
          chk("first_in_b", 64'(in_b), 64'hFFE007);
          chk("first_in_a", 64'(in_a), 64'hFFC011);
        end
        if (wr == 1023) begin
          chk("last_in_b", 64'(in_b), 64'h800801);
          chk("last_in_a", 64'(in_a), 64'h400801);
        end
        chk("load_single_cycle", 64'(prev_load), 64'd0);
        chk("addr", 64'(addr), 64'(wr));
        chk("in_a", 64'(in_a), 64'(g[47:24]));
        chk("in_b", 64'(in_b), 64'(g[23:0]));
        wr++;
      end
      prev_load = load;
      if (done) begin
        got_done = 1'b1;
        // Inclusive count from the start cycle to the done cycle.
        chk("done_latency", 64'(c + 1), 64'd37925);
        chk("busy_on_done", 64'(busy), 64'd0);
        chk("write_count", 64'(wr), 64'd1024);
        start = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("run1_done_seen", 64'(got_done), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("start_on_done_ignored", 64'(busy), 64'd0);
    chk("idle_no_load", 64'(load), 64'd0);

    // Run 2: async reset during the division of entry 500.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr    = 0;
    for (int c = 1; c < 18550; c++) begin
      if (load) wr++;
      @(posedge clk); #1;
    end
    chk("writes_before_reset", 64'(wr), 64'd500);
    chk("busy_before_reset", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_load", 64'(load), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    chk("async_addr", 64'(addr), 64'd0);
    chk("async_in_a", 64'(in_a), 64'd0);
    chk("async_in_b", 64'(in_b), 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'(busy), 64'd0);

    // Run 3: restart must rewrite from address 0 with correct values.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr    = 0;
    for (int c = 1; c <= 190; c++) begin
      if (load) begin
        g = gold(wr);
        if (wr == 0) chk("restart_first_cycle", 64'(c), 64'd72);
        chk("restart_addr", 64'(addr), 64'(wr));
        chk("restart_in_a", 64'(in_a), 64'(g[47:24]));
        chk("restart_in_b", 64'(in_b), 64'(g[23:0]));
        wr++;
      end
      @(posedge clk); #1;
    end
    chk("restart_writes", 64'(wr), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
